// File: rtl/pe_decoder_if.sv
// pe_decoder_if: index-in / one-hot-out valid/ready channel for pe_decoder.
// master: the side that drives indices in and consumes one-hots (bench, arbiter).
// slave: the decoder itself.
interface pe_decoder_if #(
  parameter int IN_W = 2
) ();
  localparam int OUT_W = 1 << IN_W;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_idx;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;

  modport master (
    output in_valid,
    output in_idx,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_onehot
  );

  modport slave (
    input  in_valid,
    input  in_idx,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_onehot
  );
endinterface

// File: rtl/pe_decoder.sv
// pe_decoder: registered binary-to-one-hot decoder with a 1-entry skid buffer
// on the input and a single output register stage. Counts output handshakes.
// Optional macro DEC_CHK_EN adds a sticky round-trip checker on port err.
module pe_decoder #(
  parameter int IN_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pe_decoder_if.slave      bus,
  output logic [CNT_W-1:0] xfer_cnt
`ifdef DEC_CHK_EN
  ,
  output logic             err
`endif
);
  localparam int OUT_W = 1 << IN_W;

  logic             out_valid_r;
  logic [OUT_W-1:0] onehot_r;
  logic             skid_valid;
  logic [IN_W-1:0]  skid_idx;
  logic             in_ready_r;
  logic [CNT_W-1:0] cnt_r;

  logic             in_hs;
  logic             out_hs;
  logic             load_slot;
  logic             do_load;
  logic [IN_W-1:0]  next_idx;

  assign in_hs     = bus.in_valid & in_ready_r;
  assign out_hs    = out_valid_r & bus.out_ready;
  // The output register may take a new value when it is empty or being drained.
  assign load_slot = ~out_valid_r | bus.out_ready;
  // The skid entry is older than anything on the input, so it always goes first.
  assign do_load   = load_slot & (skid_valid | in_hs);
  assign next_idx  = skid_valid ? skid_idx : bus.in_idx;

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_onehot = onehot_r;
  assign xfer_cnt       = cnt_r;

  // Output register, skid buffer, registered in_ready and transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      onehot_r    <= '0;
      skid_valid  <= 1'b0;
      skid_idx    <= '0;
      in_ready_r  <= 1'b1;
      cnt_r       <= '0;
    end else begin
      if (do_load) begin
        out_valid_r <= 1'b1;
        onehot_r    <= {{(OUT_W-1){1'b0}}, 1'b1} << next_idx;
        if (skid_valid) begin
          skid_valid <= 1'b0;
          in_ready_r <= 1'b1;
        end
      end else if (load_slot) begin
        out_valid_r <= 1'b0;
        onehot_r    <= '0;
      end else if (in_hs) begin
        skid_valid <= 1'b1;
        skid_idx   <= bus.in_idx;
        in_ready_r <= 1'b0;
      end
      if (out_hs) begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

`ifdef DEC_CHK_EN
  logic [IN_W-1:0] idx_r;
  logic [IN_W-1:0] enc_idx;
  logic            bad;

  // Keep the binary index that produced the current output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= '0;
    end else if (do_load) begin
      idx_r <= next_idx;
    end
  end

  // Re-encode the output word (highest set bit wins) and flag any disagreement.
  always_comb begin
    enc_idx = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (onehot_r[i]) begin
        enc_idx = i[IN_W-1:0];
      end
    end
    bad = ($countones(onehot_r) != 1) || (enc_idx != idx_r);
  end

  // Sticky error: once set only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (out_valid_r && bad) begin
      err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pe_decoder.sv
// tb_pe_decoder: directed vector table, stall/reset/wrap sequences and a
// random scoreboard run for pe_decoder. Build with DEC_CHK_EN to cover err.
module tb_pe_decoder;
  logic       clk;
  logic       rst_n;
  logic [7:0] xfer_cnt;
`ifdef DEC_CHK_EN
  logic       err;
`endif

  pe_decoder_if #(.IN_W(2)) bus ();

  pe_decoder #(.IN_W(2), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .xfer_cnt (xfer_cnt)
`ifdef DEC_CHK_EN
    ,
    .err      (err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       iv;
    logic [1:0] idx;
    logic       ordy;
    logic       ov;
    logic [3:0] oh;
    logic       ir;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[15];
  int   checks   = 0;
  int   failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [1:0] idx, input logic ordy);
    bus.in_valid  = iv;
    bus.in_idx    = idx;
    bus.out_ready = ordy;
  endtask

  int         q[$];
  int         pushed;
  int         popped;
  int         cycles;
  int         exp_idx;
  logic [1:0] ridx;

  initial begin
    // idx 0..3 back-to-back, then a stall that fills the skid, then
    // simultaneous in/out handshakes with the skid empty.
    vecs[0]  = '{1'b1, 2'd0, 1'b1, 1'b1, 4'b0001, 1'b1, 8'd0};
    vecs[1]  = '{1'b1, 2'd1, 1'b1, 1'b1, 4'b0010, 1'b1, 8'd1};
    vecs[2]  = '{1'b1, 2'd2, 1'b1, 1'b1, 4'b0100, 1'b1, 8'd2};
    vecs[3]  = '{1'b1, 2'd3, 1'b1, 1'b1, 4'b1000, 1'b1, 8'd3};
    vecs[4]  = '{1'b0, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b1, 8'd4};
    vecs[5]  = '{1'b1, 2'd2, 1'b0, 1'b1, 4'b0100, 1'b1, 8'd4};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 1'b1, 4'b0100, 1'b1, 8'd4};
    vecs[7]  = '{1'b1, 2'd3, 1'b0, 1'b1, 4'b0100, 1'b0, 8'd4};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 1'b1, 4'b0100, 1'b0, 8'd4};
    vecs[9]  = '{1'b1, 2'd0, 1'b0, 1'b1, 4'b0100, 1'b0, 8'd4};
    vecs[10] = '{1'b0, 2'd2, 1'b1, 1'b1, 4'b1000, 1'b1, 8'd5};
    vecs[11] = '{1'b0, 2'd1, 1'b1, 1'b0, 4'b0000, 1'b1, 8'd6};
    vecs[12] = '{1'b1, 2'd1, 1'b0, 1'b1, 4'b0010, 1'b1, 8'd6};
    vecs[13] = '{1'b1, 2'd3, 1'b1, 1'b1, 4'b1000, 1'b1, 8'd7};
    vecs[14] = '{1'b0, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1, 8'd8};

    applyStimulus(1'b0, 2'd0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_onehot", {28'd0, bus.out_onehot}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("reset_xfer_cnt", {24'd0, xfer_cnt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].iv, vecs[i].idx, vecs[i].ordy);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].ov});
      checkOutput($sformatf("vec%0d_onehot", i), {28'd0, bus.out_onehot}, {28'd0, vecs[i].oh});
      checkOutput($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].ir});
      checkOutput($sformatf("vec%0d_xfer_cnt", i), {24'd0, xfer_cnt}, {24'd0, vecs[i].cnt});
    end

    // Reset asserted mid-stall with the skid full.
    @(negedge clk);
    applyStimulus(1'b1, 2'd1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 2'd2, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    checkOutput("stall_onehot", {28'd0, bus.out_onehot}, 32'b0010);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("async_rst_onehot", {28'd0, bus.out_onehot}, 32'd0);
    checkOutput("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("async_rst_xfer_cnt", {24'd0, xfer_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("post_rst_onehot", {28'd0, bus.out_onehot}, 32'd0);

    // Counter wrap: 256 transfers bring it back to 0, the 257th makes it 1.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 2'(i % 4), 1'b1);
    end
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("wrap_xfer_cnt", {24'd0, xfer_cnt}, 32'd0);
    checkOutput("wrap_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 2'd3, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("wrap_plus1_xfer_cnt", {24'd0, xfer_cnt}, 32'd1);

    // Random traffic against a FIFO scoreboard.
    pushed = 0;
    popped = 0;
    cycles = 0;
    while (popped < 10000 && cycles < 80000) begin
      @(negedge clk);
      ridx = 2'($urandom_range(0, 3));
      applyStimulus((pushed < 10000) ? 1'($urandom_range(0, 1)) : 1'b0, ridx,
                    1'($urandom_range(0, 1)));
      if (q.size() == 2) begin
        checkOutput("rand_ready_when_full", {31'd0, bus.in_ready}, 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checkOutput("rand_unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_idx = q.pop_front();
          checkOutput("rand_onehot", {28'd0, bus.out_onehot}, 32'd1 << exp_idx);
        end
        popped++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(int'(ridx));
        pushed++;
      end
      cycles++;
    end
    if (popped < 10000) begin
      checkOutput("rand_timeout_popped", popped, 32'd10000);
    end
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("rand_drained_out_valid", {31'd0, bus.out_valid}, 32'd0);

`ifdef DEC_CHK_EN
    checkOutput("chk_err_clean", {31'd0, err}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 2'd1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b0);
    force dut.onehot_r = 4'b0110;
    @(posedge clk);
    #1;
    checkOutput("chk_err_set", {31'd0, err}, 32'd1);
    @(negedge clk);
    release dut.onehot_r;
    applyStimulus(1'b1, 2'd2, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("chk_err_sticky", {31'd0, err}, 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("chk_err_reset", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
